// File: rtl/mul_job_sequencer.sv
// Sequencer for a memory-mapped multiplier: writes the operands, polls the busy status,
// reads the product and the operation counter, then offers the result through a handshake.
module mul_job_sequencer #(
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned POLL_GAP   = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [23:0] job_a,
    input  logic [23:0] job_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_w,
    output logic [31:0] res_cnt,
    output logic        res_err,
    output logic [15:0] m_saddress,
    output logic        m_srd,
    output logic        m_swr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);

    localparam logic [15:0] AddrA1  = 16'h0100;
    localparam logic [15:0] AddrA2  = 16'h0108;
    localparam logic [15:0] AddrW   = 16'h0110;
    localparam logic [15:0] AddrB   = 16'h0120;
    localparam logic [15:0] AddrCnt = 16'h0130;

    localparam int unsigned PhW  = $clog2(STROBE_CYC + 2);
    localparam int unsigned PcW  = ($clog2(TIMEOUT + 1) < 6) ? 6 : $clog2(TIMEOUT + 1);
    localparam int unsigned GcW  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    // Access phases: 0 = setup, 1..STROBE_CYC = strobe high, STROBE_CYC+1 = recovery.
    localparam logic [PhW-1:0] PhLastHi = PhW'(STROBE_CYC);
    localparam logic [PhW-1:0] PhRecov  = PhW'(STROBE_CYC + 1);

    typedef enum logic [2:0] {
        StIdle,
        StWrA1,
        StWrA2,
        StPoll,
        StGap,
        StRdW,
        StRdCnt,
        StPush
    } state_e;

    state_e         state_q;
    state_e         acc_next;
    logic [PhW-1:0] ph_q;
    logic [GcW-1:0] gap_q;
    logic [PcW-1:0] poll_cnt_q;
    logic           busy_q;
    logic [31:0]    job_b_q;
    logic           is_read;
    logic           timeout;

    assign job_ready = (state_q == StIdle) && n_reset;
    assign is_read   = (state_q == StPoll) || (state_q == StRdW) || (state_q == StRdCnt);

    // State that follows the recovery cycle of the current access.
    always_comb begin
        acc_next = StIdle;
        timeout  = busy_q && (poll_cnt_q == PcW'(TIMEOUT));
        unique case (state_q)
            StWrA1:  acc_next = StWrA2;
            StWrA2:  acc_next = StPoll;
            StPoll: begin
                if (!busy_q) begin
                    acc_next = StRdW;
                end else if (timeout) begin
                    acc_next = StPush;
                end else if (POLL_GAP == 0) begin
                    acc_next = StPoll;
                end else begin
                    acc_next = StGap;
                end
            end
            StRdW:   acc_next = StRdCnt;
            StRdCnt: acc_next = StPush;
            default: acc_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q    <= StIdle;
            ph_q       <= '0;
            gap_q      <= '0;
            poll_cnt_q <= '0;
            busy_q     <= 1'b0;
            job_b_q    <= '0;
            m_srd      <= 1'b0;
            m_swr      <= 1'b0;
            m_saddress <= '0;
            m_wdata    <= '0;
            res_valid  <= 1'b0;
            res_w      <= '0;
            res_cnt    <= '0;
            res_err    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (job_valid) begin
                        job_b_q    <= {8'h00, job_b};
                        poll_cnt_q <= '0;
                        state_q    <= StWrA1;
                        ph_q       <= '0;
                        m_saddress <= AddrA1;
                        m_wdata    <= {8'h00, job_a};
                    end
                end
                StGap: begin
                    if (gap_q == GcW'(POLL_GAP - 1)) begin
                        state_q    <= StPoll;
                        ph_q       <= '0;
                        m_saddress <= AddrB;
                        m_wdata    <= '0;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                StPush: begin
                    if (res_ready) begin
                        state_q   <= StIdle;
                        res_valid <= 1'b0;
                    end
                end
                default: begin
                    if (ph_q == '0) begin
                        m_srd <= is_read;
                        m_swr <= !is_read;
                        ph_q  <= ph_q + 1'b1;
                    end else if (ph_q == PhLastHi) begin
                        m_srd <= 1'b0;
                        m_swr <= 1'b0;
                        ph_q  <= ph_q + 1'b1;
                        unique case (state_q)
                            StPoll: begin
                                busy_q     <= m_rdata[0];
                                poll_cnt_q <= poll_cnt_q + 1'b1;
                            end
                            StRdW:   res_w   <= m_rdata;
                            StRdCnt: res_cnt <= m_rdata;
                            default: ;
                        endcase
                    end else if (ph_q == PhRecov) begin
                        ph_q    <= '0;
                        state_q <= acc_next;
                        unique case (acc_next)
                            StWrA2: begin
                                m_saddress <= AddrA2;
                                m_wdata    <= job_b_q;
                            end
                            StPoll: begin
                                m_saddress <= AddrB;
                                m_wdata    <= '0;
                            end
                            StRdW: begin
                                m_saddress <= AddrW;
                                m_wdata    <= '0;
                            end
                            StRdCnt: begin
                                m_saddress <= AddrCnt;
                                m_wdata    <= '0;
                            end
                            StGap: begin
                                gap_q   <= '0;
                                m_wdata <= '0;
                            end
                            default: begin
                                // Only StPush follows here; a timeout reports zeros.
                                m_wdata   <= '0;
                                res_valid <= 1'b1;
                                res_err   <= timeout;
                                if (timeout) begin
                                    res_w   <= '0;
                                    res_cnt <= '0;
                                end
                            end
                        endcase
                    end else begin
                        ph_q <= ph_q + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
